code_entry_controller: RTL and testbench



---
 rtl/code_entry_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_code_entry_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_controller.sv
// Keypad-lock front end: conditions four raw buttons, collects a four-symbol code,
// compares it with SECRET and drives the 7-segment result, fail counter and lockout.
module code_entry_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [7:0]  SECRET          = 8'b11_10_10_00,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned SHOW_CYCLES     = 16,
  parameter int unsigned LOCK_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttonTop,
  input  logic       buttonDown,
  input  logic       buttonLeft,
  input  logic       buttonRight,
  output logic [6:0] SSG_D,
  output logic       unlock,
  output logic       locked,
  output logic [2:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_SHOW_OK, S_SHOW_ERR, S_LOCKED
  } state_e;

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TMR_MAX = (SHOW_CYCLES > LOCK_CYCLES)
                                    ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                                    : ((LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       FAIL_MAX  = 3'(MAX_FAIL);

  // Active-low segments, {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_L = 7'b1000111;

  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] clean_q, clean_d, clean_prev_q;
  logic [3:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  logic [3:0] press_ev;
  logic       press, multi;
  logic [1:0] sym;

  state_e            state_q, state_d;
  logic [7:0]        entry_q, entry_d;
  logic [1:0]        idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        fail_q, fail_d, fail_next;
  logic              attempt_ok;
  logic [6:0]        ssg_q, ssg_d;
  logic              unlock_q, unlock_d;
  logic              locked_q, locked_d;

  assign raw = {buttonRight, buttonLeft, buttonDown, buttonTop};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      clean_q      <= '0;
      clean_prev_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clean_d  = clean_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        clean_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Simultaneous presses collapse to one, with the lowest-numbered symbol winning.
  assign press_ev = clean_q & ~clean_prev_q;

  always_comb begin
    press = |press_ev;
    multi = ($countones(press_ev) > 1);
    sym   = 2'd0;
    if      (press_ev[0]) sym = 2'd0;
    else if (press_ev[1]) sym = 2'd1;
    else if (press_ev[2]) sym = 2'd2;
    else if (press_ev[3]) sym = 2'd3;
  end

  assign attempt_ok = (entry_q == SECRET) && !bad_q;
  assign fail_next  = (fail_q == FAIL_MAX) ? fail_q : fail_q + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (press) state_d = S_ENTRY;
      S_ENTRY: begin
        if (press) begin
          if (idx_q == 2'd3) state_d = S_CHECK;
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (attempt_ok)                 state_d = S_SHOW_OK;
        else if (fail_next == FAIL_MAX) state_d = S_LOCKED;
        else                            state_d = S_SHOW_ERR;
      end
      S_SHOW_OK, S_SHOW_ERR, S_LOCKED: if (tmr_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      tmr_q   <= '0;
      fail_q  <= '0;
    end else begin
      entry_q <= entry_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
    end
  end

  // One shared down-counter serves the entry timeout, the glyph hold and the lockout.
  always_comb begin
    entry_d = entry_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        if (press) begin
          entry_d[{idx_q, 1'b0} +: 2] = sym;
          idx_d = idx_q + 2'd1;
          bad_d = bad_q | multi;
          tmr_d = TO_LOAD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (attempt_ok) begin
          fail_d = '0;
          tmr_d  = SHOW_LOAD;
        end else begin
          fail_d = fail_next;
          tmr_d  = (fail_next == FAIL_MAX) ? LOCK_LOAD : SHOW_LOAD;
        end
      end
      S_SHOW_OK, S_SHOW_ERR: if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
      S_LOCKED: begin
        if (tmr_q == '0) fail_d = '0;
        else             tmr_d  = tmr_q - 1'b1;
      end
      default: ;
    endcase
    if (state_d == S_IDLE) begin
      entry_d = '0;
      idx_d   = '0;
      bad_d   = 1'b0;
    end
  end

  // unlock is registered from the ENTRY->CHECK transition so it is high in the CHECK cycle.
  always_comb begin
    ssg_d    = ssg_q;
    unlock_d = (state_q == S_ENTRY) && (state_d == S_CHECK) && (entry_d == SECRET) && !bad_d;
    locked_d = (state_d == S_LOCKED);
    unique case (state_q)
      S_IDLE:  ssg_d = GLYPH_0;
      S_ENTRY: begin
        unique case (idx_q)
          2'd1:    ssg_d = GLYPH_1;
          2'd2:    ssg_d = GLYPH_2;
          2'd3:    ssg_d = GLYPH_3;
          default: ssg_d = GLYPH_0;
        endcase
      end
      S_CHECK:    ssg_d = ssg_q;
      S_SHOW_OK:  ssg_d = GLYPH_9;
      S_SHOW_ERR: ssg_d = GLYPH_E;
      S_LOCKED:   ssg_d = GLYPH_L;
      default:    ssg_d = GLYPH_0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ssg_q    <= GLYPH_0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      ssg_q    <= ssg_d;
      unlock_q <= unlock_d;
      locked_q <= locked_d;
    end
  end

  assign SSG_D      = ssg_q;
  assign unlock     = unlock_q;
  assign locked     = locked_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_code_entry_controller.sv
// Scoreboard bench for code_entry_controller: attempts push their expected outcome,
// a negedge monitor pops and compares when the display shows a result glyph.
module tb_code_entry_controller;

  localparam int         SHOW   = 16;
  localparam int         LOCK   = 64;
  localparam int         MAXF   = 3;
  localparam logic [7:0] SECRET = 8'b11_10_10_00;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GL = 7'b1000111;

  localparam logic [3:0] BT = 4'b0001;
  localparam logic [3:0] BD = 4'b0010;
  localparam logic [3:0] BL = 4'b0100;
  localparam logic [3:0] BR = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [6:0] SSG_D;
  logic       unlock;
  logic       locked;
  logic [2:0] fail_count;

  always #5 clk = ~clk;

  code_entry_controller #(
    .DEBOUNCE_CYCLES(4), .SECRET(SECRET), .MAX_FAIL(MAXF),
    .SHOW_CYCLES(SHOW), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttonTop  (btn[0]),
    .buttonDown (btn[1]),
    .buttonLeft (btn[2]),
    .buttonRight(btn[3]),
    .SSG_D      (SSG_D),
    .unlock     (unlock),
    .locked     (locked),
    .fail_count (fail_count)
  );

  typedef struct {
    logic [6:0] glyph;
    logic       unl;
    logic [2:0] fc;
    int         len;
  } outcome_t;

  outcome_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int model_fail  = 0;

  function automatic logic [1:0] sym_of(input logic [3:0] m);
    sym_of = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) sym_of = 2'(i);
  endfunction

  task automatic push_attempt(input logic [3:0] m0, input logic [3:0] m1,
                              input logic [3:0] m2, input logic [3:0] m3);
    logic [3:0] m [4];
    logic [7:0] code;
    logic       bad;
    outcome_t   e;
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    code = '0;
    bad  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      code[2*i +: 2] = sym_of(m[i]);
      if ($countones(m[i]) > 1) bad = 1'b1;
    end
    if (code == SECRET && !bad) begin
      model_fail = 0;
      e.glyph = G9; e.unl = 1'b1; e.len = SHOW;
    end else begin
      model_fail++;
      e.unl = 1'b0;
      if (model_fail == MAXF) begin e.glyph = GL; e.len = LOCK; end
      else begin e.glyph = GE; e.len = SHOW; end
    end
    e.fc = 3'(model_fail);
    exp_q.push_back(e);
    if (model_fail == MAXF) model_fail = 0;
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int rel);
    @(posedge clk); #1 btn = m;
    repeat (hold) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic enter_code(input logic [3:0] m0, input logic [3:0] m1,
                            input logic [3:0] m2, input logic [3:0] m3);
    push_attempt(m0, m1, m2, m3);
    press(m0, 10, 10);
    press(m1, 10, 10);
    press(m2, 10, 10);
    press(m3, 10, 10);
  endtask

  // Monitor: result glyphs, their hold time, unlock pulse width and lockout length.
  logic [6:0] prev_ssg;
  int         run_len, cur_exp_len, locked_len;
  bit         prev_unlock, unlock_seen;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_ssg = G0; run_len = 0; cur_exp_len = 0; locked_len = 0;
      prev_unlock = 1'b0; unlock_seen = 1'b0;
    end else begin
      if (unlock === 1'b1) begin
        vectors++;
        if (prev_unlock) begin
          miscompares++;
          $display("FAIL unlock_width: unlock high on consecutive cycles, expected one-cycle pulse");
        end
        unlock_seen = 1'b1;
      end
      prev_unlock = (unlock === 1'b1);
      if (locked === 1'b1) locked_len++;
      else if (locked_len != 0) begin
        vectors++;
        if (locked_len != LOCK) begin
          miscompares++;
          $display("FAIL lock_len: locked high %0d cycles, expected %0d", locked_len, LOCK);
        end
        locked_len = 0;
      end
      if (SSG_D !== prev_ssg) begin
        if (cur_exp_len != 0) begin
          vectors++;
          if (run_len != cur_exp_len || SSG_D !== G0) begin
            miscompares++;
            $display("FAIL glyph_hold: held %0d cycles then %b, expected %0d then %b",
                     run_len, SSG_D, cur_exp_len, G0);
          end
          cur_exp_len = 0;
        end
        if (SSG_D === G9 || SSG_D === GE || SSG_D === GL) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL outcome_unexpected: glyph %b with no attempt pending", SSG_D);
          end else begin
            outcome_t e;
            e = exp_q.pop_front();
            if (SSG_D !== e.glyph || unlock_seen !== e.unl || fail_count !== e.fc) begin
              miscompares++;
              $display("FAIL outcome: glyph=%b unlock=%0b fail_count=%0d, expected glyph=%b unlock=%0b fail_count=%0d",
                       SSG_D, unlock_seen, fail_count, e.glyph, e.unl, e.fc);
            end
            cur_exp_len = e.len;
          end
          unlock_seen = 1'b0;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_ssg = SSG_D;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || unlock !== 1'b0 || locked !== 1'b0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_hold: SSG_D=%b unlock=%b locked=%b fail=%0d, expected %b 0 0 0",
               SSG_D, unlock, locked, fail_count, G0);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: SSG_D=%b fail=%0d, expected %b 0", SSG_D, fail_count, G0);
    end
  endtask

  task automatic test_correct_code();
    logic [6:0] steps [3];
    logic [3:0] seq   [4];
    steps[0] = G1; steps[1] = G2; steps[2] = G3;
    seq[0] = BT; seq[1] = BL; seq[2] = BL; seq[3] = BR;
    push_attempt(BT, BL, BL, BR);
    for (int i = 0; i < 4; i++) begin
      press(seq[i], 10, 10);
      @(negedge clk);
      vectors++;
      if (SSG_D !== ((i < 3) ? steps[i] : G9)) begin
        miscompares++;
        $display("FAIL t1_step%0d: SSG_D=%b expected %b", i, SSG_D, (i < 3) ? steps[i] : G9);
      end
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL t1_done: SSG_D=%b fail=%0d, expected %b 0", SSG_D, fail_count, G0);
    end
  endtask

  task automatic test_lockout();
    int n;
    for (int k = 1; k <= 3; k++) begin
      enter_code(BT, BD, BL, BR);
      @(negedge clk);
      vectors++;
      if (fail_count !== 3'(k) || locked !== (k == 3)) begin
        miscompares++;
        $display("FAIL t2_fail%0d: fail=%0d locked=%b, expected %0d %0b", k, fail_count, locked, k, k == 3);
      end
      if (k < 3) begin repeat (10) @(posedge clk); #1; end
    end
    press(BT, 10, 0);
    #1 btn = BR;
    n = 0;
    while (locked === 1'b1 && n < 200) begin @(posedge clk); n++; end
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL t2_lock_exit: locked=%b after %0d cycles, expected 0", locked, n);
    end
    repeat (20) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (10) @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL t2_after_lock: SSG_D=%b fail=%0d, expected %b 0", SSG_D, fail_count, G0);
    end
  endtask

  task automatic test_glitch();
    int  blen [8];
    bit  lev;
    bit  disturbed;
    blen[0] = 2; blen[1] = 1; blen[2] = 3; blen[3] = 2;
    blen[4] = 1; blen[5] = 1; blen[6] = 2; blen[7] = 12;
    disturbed = 1'b0;
    @(posedge clk); #1 btn = BL;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (SSG_D !== G0) disturbed = 1'b1; @(posedge clk); #1; end
    btn = 4'b0000;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (SSG_D !== G0) disturbed = 1'b1; @(posedge clk); #1; end
    lev = 1'b1;
    for (int s = 0; s < 8; s++) begin
      btn = lev ? BL : 4'b0000;
      for (int c = 0; c < blen[s]; c++) begin
        @(negedge clk); if (SSG_D !== G0) disturbed = 1'b1;
        @(posedge clk); #1;
      end
      lev = !lev;
    end
    vectors++;
    if (disturbed || SSG_D !== G0) begin
      miscompares++;
      $display("FAIL t3_glitch: display left %b during short pulses, expected %b throughout", SSG_D, G0);
    end
    push_attempt(BT, BL, BL, BR);
    @(posedge clk); #1 btn = BT;
    repeat (8) @(negedge clk);
    vectors++;
    if (SSG_D !== G0) begin
      miscompares++;
      $display("FAIL t3_early: SSG_D=%b at rise+7, expected %b", SSG_D, G0);
    end
    @(negedge clk);
    vectors++;
    if (SSG_D !== G1) begin
      miscompares++;
      $display("FAIL t3_latency: SSG_D=%b at rise+8, expected %b", SSG_D, G1);
    end
    repeat (2) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    press(BL, 10, 10);
    press(BL, 10, 10);
    press(BR, 10, 10);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    enter_code(BT | BL, BL, BL, BR);
    @(negedge clk);
    vectors++;
    if (SSG_D !== GE || fail_count !== 3'd1) begin
      miscompares++;
      $display("FAIL t4_bad: SSG_D=%b fail=%0d, expected %b 1", SSG_D, fail_count, GE);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    press(BT, 10, 10);
    press(BL, 10, 10);
    repeat (230) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (SSG_D !== G2) begin
      miscompares++;
      $display("FAIL t5_before_timeout: SSG_D=%b expected %b", SSG_D, G2);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'(model_fail)) begin
      miscompares++;
      $display("FAIL t5_timeout: SSG_D=%b fail=%0d, expected %b %0d", SSG_D, fail_count, G0, model_fail);
    end
    @(posedge clk); #1;
    enter_code(BT, BL, BL, BR);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(BD, BD, BD, BD);
      if (k < 2) begin repeat (10) @(posedge clk); #1; end
    end
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (SSG_D !== G0 || locked !== 1'b0 || unlock !== 1'b0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL t6_reset_lock: SSG_D=%b locked=%b unlock=%b fail=%0d, expected %b 0 0 0",
               SSG_D, locked, unlock, fail_count, G0);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_fail = 0;
    press(BT, 10, 10);
    press(BL, 10, 10);
    @(negedge clk);
    vectors++;
    if (SSG_D !== G2) begin
      miscompares++;
      $display("FAIL t6_mid_entry: SSG_D=%b expected %b", SSG_D, G2);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL t6_reset_entry: SSG_D=%b fail=%0d, expected %b 0", SSG_D, fail_count, G0);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    enter_code(BT, BL, BL, BR);
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (SSG_D !== G0 || fail_count !== 3'd0) begin
      miscompares++;
      $display("FAIL t6_final: SSG_D=%b fail=%0d, expected %b 0", SSG_D, fail_count, G0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_correct_code();
    test_lockout();
    test_glitch();
    test_simultaneous();
    test_timeout();
    test_async_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_outcomes: %0d attempts never reported, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
